// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the scan sequencer slice.
//   state_t      - sequencer FSM states (IDLE, SCAN)
//   DEF_SEL_W    - default select width
//   DEF_DWELL_W  - default dwell-time field width
//   num_ch()     - channel count derived from a select width (2**sel_w)
//   MODE_CONT / MODE_SINGLE - scan mode encodings
package scan_pkg;

  localparam int DEF_SEL_W   = 3;
  localparam int DEF_DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  function automatic int num_ch(input int sel_w);
    return 2 ** sel_w;
  endfunction

endpackage

// File: rtl/scan_sequencer_next.sv
// next_set_index: combinational channel search over a channel mask.
//   mask       (in)  channel enable mask, one bit per channel
//   idx        (in)  current channel index
//   next_idx   (out) lowest set bit strictly above idx (0 when none)
//   none_above (out) no set bit above idx
//   lowest     (out) lowest set bit of mask (0 when mask is empty)
module next_set_index
  import scan_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [(2**SEL_W)-1:0] mask,
  input  logic [SEL_W-1:0]      idx,
  output logic [SEL_W-1:0]      next_idx,
  output logic                  none_above,
  output logic [SEL_W-1:0]      lowest
);

  localparam int NCH = num_ch(SEL_W);

  // Walk from the top channel down so the last hit is the lowest match.
  always_comb begin
    next_idx   = '0;
    none_above = 1'b1;
    lowest     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_W'(i);
        if (i > int'(idx)) begin
          next_idx   = SEL_W'(i);
          none_above = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a decoder select code through the channels enabled
// in a mask, holding each for a programmable number of enabled cycles.
//   clk       (in)  clock, rising edge
//   rst_n     (in)  asynchronous active-low reset
//   start     (in)  begin a scan (only honoured in IDLE)
//   stop      (in)  abort the scan
//   en        (in)  dwell count enable; 0 pauses the current slot
//   mode      (in)  0 = continuous, 1 = single pass
//   mask      (in)  channel enable mask, latched at start
//   dwell     (in)  cycles per channel, latched at start (0 treated as 1)
//   sel_o     (out) select code to the decoder
//   sel_valid (out) sel_o is an active scan slot
//   busy      (out) sequencer is scanning
//   wrap      (out) pulse: continuous scan restarted at the lowest channel
//   done      (out) pulse: single pass completed
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  en,
  input  logic                  mode,
  input  logic [(2**SEL_W)-1:0] mask,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  sel_valid,
  output logic                  busy,
  output logic                  wrap,
  output logic                  done
);

  localparam int NCH = num_ch(SEL_W);

  state_t               state, state_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   cnt, cnt_d;
  logic [SEL_W-1:0]     sel_d;
  logic                 valid_d, busy_d, wrap_d, done_d;

  logic [NCH-1:0]       search_mask;
  logic [SEL_W-1:0]     next_idx, lowest;
  logic                 none_above;
  logic [DWELL_W-1:0]   dwell_eff;

  // One search unit serves both states: in IDLE it finds the first channel
  // of the incoming mask, in SCAN it finds the successor in the latched mask.
  assign search_mask = (state == IDLE) ? mask : mask_q;
  assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;

  next_set_index #(
    .SEL_W(SEL_W)
  ) u_next (
    .mask       (search_mask),
    .idx        (sel_o),
    .next_idx   (next_idx),
    .none_above (none_above),
    .lowest     (lowest)
  );

  // Next-state and next-output logic; stop outranks both start and slot end.
  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    cnt_d   = cnt;
    sel_d   = sel_o;
    valid_d = sel_valid;
    busy_d  = busy;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && (mask != '0)) begin
          state_d = SCAN;
          mask_d  = mask;
          dwell_d = dwell_eff;
          mode_d  = mode;
          cnt_d   = dwell_eff;
          sel_d   = lowest;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (en) begin
          // cnt counts down from dwell_q; reaching 1 closes the slot and reloads.
          if (cnt <= DWELL_W'(1)) begin
            cnt_d = dwell_q;
            if (!none_above) begin
              sel_d = next_idx;
            end else if (mode_q == MODE_CONT) begin
              sel_d  = lowest;
              wrap_d = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt - DWELL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched scan parameters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= MODE_CONT;
      cnt       <= '0;
      sel_o     <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      cnt       <= cnt_d;
      sel_o     <= sel_d;
      sel_valid <= valid_d;
      busy      <= busy_d;
      wrap      <= wrap_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: self-checking bench for scan_sequencer.
// Hand-written vector table, directed multi-cycle sequences, and random
// stimulus compared against a channel-list reference model.
module tb_scan_sequencer;

  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] sel_o;
  logic       sel_valid, busy, wrap, done;

  int checks = 0;
  int errors = 0;

  // Reference model: the scan is a list of enabled channels walked in order,
  // each slot consuming dwell enabled cycles.
  int         m_list[$];
  int         m_pos, m_used, m_dq;
  logic       m_mode, m_busy;
  logic [2:0] e_sel;
  logic       e_valid, e_wrap, e_done;

  typedef struct {
    logic       start, stop, en, mode;
    logic [7:0] mask, dwell;
    logic [2:0] sel;
    logic       valid, busy, wrap, done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .mode      (mode),
    .mask      (mask),
    .dwell     (dwell),
    .sel_o     (sel_o),
    .sel_valid (sel_valid),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_list.delete();
    m_pos = 0; m_used = 0; m_dq = 1;
    m_mode = 1'b0; m_busy = 1'b0;
    e_sel = 3'd0; e_valid = 1'b0; e_wrap = 1'b0; e_done = 1'b0;
  endtask

  task automatic modelStep();
    e_wrap = 1'b0;
    e_done = 1'b0;
    if (!m_busy) begin
      if (start && !stop && mask != 8'h00) begin
        m_list.delete();
        for (int c = 0; c < NC; c++) if (mask[c]) m_list.push_back(c);
        m_pos = 0; m_used = 0;
        m_dq = (dwell == 8'd0) ? 1 : int'(dwell);
        m_mode = mode; m_busy = 1'b1;
        e_valid = 1'b1; e_sel = 3'(m_list[0]);
      end
    end else if (stop) begin
      m_busy = 1'b0; e_valid = 1'b0;
    end else if (en) begin
      m_used++;
      if (m_used == m_dq) begin
        m_used = 0;
        if (m_pos + 1 < m_list.size()) begin
          m_pos++; e_sel = 3'(m_list[m_pos]);
        end else if (m_mode == 1'b0) begin
          m_pos = 0; e_sel = 3'(m_list[0]); e_wrap = 1'b1;
        end else begin
          m_busy = 1'b0; e_valid = 1'b0; e_done = 1'b1;
        end
      end
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge act, settle at the next falling edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic e,
                               input logic md, input logic [7:0] mk, input logic [7:0] dw);
    start = st; stop = sp; en = e; mode = md; mask = mk; dwell = dw;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] s, input logic v,
                             input logic b, input logic w, input logic d);
    checkField({name, ".sel_o"}, 8'(sel_o), 8'(s));
    checkField({name, ".sel_valid"}, 8'(sel_valid), 8'(v));
    checkField({name, ".busy"}, 8'(busy), 8'(b));
    checkField({name, ".wrap"}, 8'(wrap), 8'(w));
    checkField({name, ".done"}, 8'(done), 8'(d));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, e_sel, e_valid, m_busy, e_wrap, e_done);
  endtask

  task automatic addVec(input logic st, input logic sp, input logic e, input logic md,
                        input logic [7:0] mk, input logic [7:0] dw, input logic [2:0] s,
                        input logic v, input logic b, input logic w, input logic d);
    vec_t x;
    x.start = st; x.stop = sp; x.en = e; x.mode = md; x.mask = mk; x.dwell = dw;
    x.sel = s; x.valid = v; x.busy = b; x.wrap = w; x.done = d;
    vecs.push_back(x);
  endtask

  initial begin
    $display("[TB] scan_sequencer bench starting");
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Mid-scan asynchronous reset.
    applyStimulus(1, 0, 1, 0, 8'hFF, 8'd4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 8'hFF, 8'd4);
    checkOutput("pre_reset", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single pass, idle edge cases, pause, start-in-scan, and stop.
    addVec(1, 0, 1, 1, 8'hA4, 8'd1, 3'd2, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'h00, 8'd9, 3'd5, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 8'hFF, 8'd9, 3'd7, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 8'hFF, 8'd9, 3'd7, 0, 0, 0, 1);
    addVec(0, 0, 1, 0, 8'hFF, 8'd9, 3'd7, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 8'h00, 8'd3, 3'd7, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 8'hFF, 8'd3, 3'd7, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 8'hFF, 8'd3, 3'd7, 0, 0, 0, 0);
    addVec(1, 0, 1, 0, 8'h03, 8'd3, 3'd0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
    addVec(1, 0, 1, 1, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 8'hF0, 8'd1, 3'd0, 1, 1, 1, 0);
    addVec(0, 1, 1, 1, 8'hF0, 8'd1, 3'd0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].mode,
                    vecs[i].mask, vecs[i].dwell);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid,
                  vecs[i].busy, vecs[i].wrap, vecs[i].done);
    end

    // Full continuous scan, dwell 2: wrap only on the second channel-0 slot.
    applyStimulus(1, 0, 1, 0, 8'hFF, 8'd2);
    checkOutput("cont0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(0, 0, 1, 0, 8'hFF, 8'd2);
      checkOutput($sformatf("cont%0d", i), 3'((i / 2) % 8), 1'b1, 1'b1,
                  (i == 16) ? 1'b1 : 1'b0, 1'b0);
    end
    applyStimulus(0, 1, 1, 0, 8'hFF, 8'd2);
    checkOutput("cont_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single channel with dwell 0 (treated as 1), then dwell 3.
    applyStimulus(1, 0, 1, 0, 8'h10, 8'd0);
    checkOutput("single_d0_start", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 1, 0, 8'h10, 8'd0);
      checkOutput($sformatf("single_d0_%0d", i), 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(0, 1, 1, 0, 8'h10, 8'd0);
    checkOutput("single_stop", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 1, 0, 8'h10, 8'd3);
    checkOutput("single_d3_start", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(0, 0, 1, 0, 8'h10, 8'd3);
      checkOutput($sformatf("single_d3_%0d", i), 3'd4, 1'b1, 1'b1,
                  (i % 3 == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    applyStimulus(0, 1, 1, 0, 8'h10, 8'd3);
    checkOutput("single_d3_stop", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic       r_st, r_sp, r_en, r_md;
      logic [7:0] r_mk, r_dw;
      r_st = ($urandom % 4) == 0;
      r_sp = ($urandom % 40) == 0;
      r_en = ($urandom % 5) != 0;
      r_md = 1'($urandom % 2);
      r_mk = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
      r_dw = 8'($urandom % 6);
      applyStimulus(r_st, r_sp, r_en, r_md, r_mk, r_dw);
      checkModel($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
